// File: rtl/mac_pkg.sv
// mac_pkg: shared types, default widths and arithmetic helpers for the
// streaming multiply-accumulate sequencer (mac_stream_seq).
//
// Contents:
//   state_e    sequencer states IDLE / RUN / DRAIN / OUT
//   DEF_*      default operand, accumulator and burst-length widths
//   sign_ext   sign-extend the low w bits of a MAX_W-bit value
//   sat_add    w-bit signed add that clamps on overflow and flags it
//
// Helpers work on MAX_W-bit containers with a runtime width argument so one
// function serves every parameterisation; callers size-cast the result down.
// Widths above MAX_W are not supported.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int DEF_WIDTH_A = 18;
  localparam int DEF_WIDTH_B = 18;
  localparam int DEF_WIDTH_P = 48;
  localparam int DEF_LEN_W   = 5;
  localparam int MAX_W       = 64;

  // Replicate bit w-1 of v into every bit above it.
  function automatic logic [MAX_W-1:0] sign_ext(input logic [MAX_W-1:0] v,
                                                input int               w);
    logic [MAX_W-1:0] signBit;
    logic [MAX_W-1:0] lowMask;
    signBit = MAX_W'(1) << (w - 1);
    // For w == MAX_W the shift wraps to zero and the mask becomes all ones.
    lowMask = (signBit << 1) - MAX_W'(1);
    if ((v & signBit) != '0) return v | ~lowMask;
    else                     return v & lowMask;
  endfunction

  // Signed add in the low w bits. Overflow only happens when both operands
  // share a sign and the sum's sign differs; the result then clamps to the
  // extreme value on the operands' side.
  function automatic logic [MAX_W-1:0] sat_add(input  logic [MAX_W-1:0] a,
                                               input  logic [MAX_W-1:0] b,
                                               input  int               w,
                                               output logic             ovf);
    logic [MAX_W-1:0] sum;
    logic [MAX_W-1:0] signBit;
    logic [MAX_W-1:0] maxPos;
    logic             aNeg;
    logic             bNeg;
    logic             sNeg;
    sum     = a + b;
    signBit = MAX_W'(1) << (w - 1);
    maxPos  = signBit - MAX_W'(1);
    aNeg    = (a & signBit) != '0;
    bNeg    = (b & signBit) != '0;
    sNeg    = (sum & signBit) != '0;
    ovf     = (aNeg == bNeg) && (sNeg != aNeg);
    if (ovf) sum = aNeg ? ~maxPos : maxPos;
    return sum;
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: one DSP-slice pipeline register.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high clear
//   ce    clock enable
//   sclr  synchronous clear, wins over ce
//   d     next value
//   q     registered value
module dsp_pipe_reg #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (sclr) q <= '0;
    else if (ce)   q <= d;
  end

endmodule

// File: rtl/mac_stream_seq.sv
// mac_stream_seq: streaming multiply-accumulate sequencer driving a
// registered A/B -> M -> P DSP pipeline. A burst of len signed operand pairs
// is accepted over a valid/ready handshake; one accumulated result is then
// offered over a second valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-high reset (1 = clear all state)
//   start/len  begin a burst of len pairs; sampled only in IDLE
//   in_valid/in_ready/in_a/in_b     operand stream
//   out_valid/out_ready/out_p       accumulated result
//   busy       high in every state except IDLE
//   ovf        (MAC_SAT_EN only) sticky per-burst saturation flag
//
// Build option MAC_SAT_EN: the accumulator saturates instead of wrapping,
// and the ovf output is added.
module mac_stream_seq
  import mac_pkg::*;
#(
  parameter int WIDTH_A = DEF_WIDTH_A,
  parameter int WIDTH_B = DEF_WIDTH_B,
  parameter int WIDTH_P = DEF_WIDTH_P,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] in_a,
  input  logic [WIDTH_B-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] out_p,
  output logic               busy
`ifdef MAC_SAT_EN
  ,
  output logic               ovf
`endif
);

  localparam int PW = WIDTH_A + WIDTH_B;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, cnt_q;
  logic               v1_q, v2_q;
  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic [PW-1:0]      m_q, m_d;
  logic [WIDTH_P-1:0] acc_q, acc_d;
  logic [WIDTH_P-1:0] prodExt;
  logic               accept;
  logic               startBurst;
  logic               inReady;
  logic               outValid;

  // Next-state logic. RUN leaves only once every beat has been counted;
  // DRAIN waits for both pipeline valid bits to empty, which means the last
  // product has landed in the accumulator.
  always_comb begin
    state_d    = state_q;
    inReady    = 1'b0;
    outValid   = 1'b0;
    startBurst = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          startBurst = 1'b1;
          state_d    = (len != '0) ? RUN : OUT;
        end
      end
      RUN: begin
        inReady = (cnt_q < len_q);
        if (cnt_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (!v1_q && !v2_q) state_d = OUT;
      end
      OUT: begin
        outValid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && inReady;

  // Control registers: state, burst length, beat counter and the valid bits
  // that travel alongside the A/B and M stages.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      v1_q    <= accept;
      v2_q    <= v1_q;
      if (startBurst) begin
        len_q <= len;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  // Operands are sign-extended to the product width so the low PW bits of
  // the unsigned multiply equal the signed product.
  assign m_d = {{WIDTH_B{a_q[WIDTH_A-1]}}, a_q} * {{WIDTH_A{b_q[WIDTH_B-1]}}, b_q};

  always_comb begin
    prodExt = WIDTH_P'(sign_ext(MAX_W'(m_q), PW));
  end

`ifdef MAC_SAT_EN
  logic ovfHit;
  logic ovf_q;

  always_comb begin
    ovfHit = 1'b0;
    acc_d  = WIDTH_P'(sat_add(MAX_W'(acc_q), MAX_W'(prodExt), WIDTH_P, ovfHit));
  end

  // Sticky overflow flag, scoped to one burst.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)                 ovf_q <= 1'b0;
    else if (startBurst)      ovf_q <= 1'b0;
    else if (v2_q && ovfHit)  ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    acc_d = acc_q + prodExt;
  end
`endif

  dsp_pipe_reg #(.WIDTH(WIDTH_A)) u_a_reg (
    .clk(clk), .rst(rstn), .ce(accept), .sclr(1'b0), .d(in_a), .q(a_q)
  );

  dsp_pipe_reg #(.WIDTH(WIDTH_B)) u_b_reg (
    .clk(clk), .rst(rstn), .ce(accept), .sclr(1'b0), .d(in_b), .q(b_q)
  );

  dsp_pipe_reg #(.WIDTH(PW)) u_m_reg (
    .clk(clk), .rst(rstn), .ce(v1_q), .sclr(1'b0), .d(m_d), .q(m_q)
  );

  // The accumulator is cleared as the burst starts, so a zero-length burst
  // reports zero.
  dsp_pipe_reg #(.WIDTH(WIDTH_P)) u_acc_reg (
    .clk(clk), .rst(rstn), .ce(v2_q), .sclr(startBurst), .d(acc_d), .q(acc_q)
  );

  assign in_ready  = inReady;
  assign out_valid = outValid;
  assign out_p     = acc_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_stream_seq.sv
// tb_mac_stream_seq: directed self-checking bench for mac_stream_seq.
// With MAC_SAT_EN defined the DUT is built with a 36-bit accumulator so the
// max-magnitude burst saturates; otherwise the default 48-bit accumulator
// holds it exactly.
module tb_mac_stream_seq;

`ifdef MAC_SAT_EN
  localparam int TB_WP = 36;
`else
  localparam int TB_WP = 48;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [4:0]       len;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic             out_valid;
  logic             out_ready;
  logic [TB_WP-1:0] out_p;
  logic             busy;
`ifdef MAC_SAT_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mac_stream_seq #(
    .WIDTH_A(18), .WIDTH_B(18), .WIDTH_P(TB_WP), .LEN_W(5)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
`ifdef MAC_SAT_EN
    , .ovf(ovf)
`endif
  );

  // Present one operand pair from a negedge and hold it until accepted.
  // Returns at the negedge following the accepting posedge.
  task automatic applyStimulus(input logic [17:0] a, input logic [17:0] b,
                               output bit ok);
    bit wasReady;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      wasReady = in_ready;
      @(negedge clk);
      ok = wasReady;
    end
    in_valid = 1'b0;
  endtask

  // One-cycle start pulse from a negedge.
  task automatic applyStartStimulus(input logic [4:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_p !== '0) begin errors++; $display("[TB] FAIL reset_out_p: got %0d expected 0", $signed(out_p)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic_burst();
    bit ok;
    bit allOk;
    int cyc;
    logic [TB_WP-1:0] expP;
    allOk     = 1'b1;
    out_ready = 1'b1;
    applyStartStimulus(5'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_run: got %b expected 1", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready_run: got %b expected 1", in_ready); end
    applyStimulus(18'(2), 18'(3), ok);   allOk &= ok;
    applyStimulus(18'(-4), 18'(5), ok);  allOk &= ok;
    applyStimulus(18'(7), 18'(-1), ok);  allOk &= ok;
    checks++; if (allOk !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept: got %b expected 1", allOk); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 3", cyc); end
    expP = TB_WP'(-21);
    checks++; if (out_p !== expP) begin errors++; $display("[TB] FAIL basic_out_p: got %0d expected -21", $signed(out_p)); end
    // start during the OUT handshake cycle must be ignored
    start = 1'b1;
    len   = 5'd2;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_single_result: got %b expected 0", out_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_start_ignored: got %b expected 0", busy); end
  endtask

  task automatic test_bubbles_backpressure();
    bit ok;
    bit allOk;
    int cyc;
    logic [TB_WP-1:0] expP;
    allOk     = 1'b1;
    out_ready = 1'b0;
    applyStartStimulus(5'd2);
    applyStimulus(18'(100), 18'(-3), ok);  allOk &= ok;
    repeat (2) @(negedge clk);
    applyStimulus(18'(-50), 18'(-7), ok);  allOk &= ok;
    checks++; if (allOk !== 1'b1) begin errors++; $display("[TB] FAIL bubble_accept: got %b expected 1", allOk); end
    // an extra offered beat must not be taken
    in_a     = 18'(9);
    in_b     = 18'(9);
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bubble_in_ready_full: got %b expected 0", in_ready); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (cyc > 3) begin errors++; $display("[TB] FAIL bubble_out_wait: got %0d cycles expected at most 3", cyc); end
    expP = TB_WP'(50);
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bubble_hold_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (out_p !== expP) begin errors++; $display("[TB] FAIL bubble_hold_p[%0d]: got %0d expected 50", k, $signed(out_p)); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bubble_valid_at_accept: got %b expected 1", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bubble_valid_after: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bubble_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_zero_len();
    out_ready = 1'b0;
    in_a      = 18'(3);
    in_b      = 18'(3);
    in_valid  = 1'b1;
    applyStartStimulus(5'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_out_valid: got %b expected 1", out_valid); end
    checks++; if (out_p !== '0) begin errors++; $display("[TB] FAIL zero_out_p: got %0d expected 0", $signed(out_p)); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL zero_in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_valid_after: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_max_magnitude();
    bit ok;
    bit allOk;
    int cyc;
    logic [TB_WP-1:0] expP;
    allOk     = 1'b1;
    out_ready = 1'b0;
    applyStartStimulus(5'd31);
    for (int i = 0; i < 31; i++) begin
      applyStimulus(18'h20000, 18'h20000, ok);
      allOk &= ok;
    end
    checks++; if (allOk !== 1'b1) begin errors++; $display("[TB] FAIL max_accept: got %b expected 1", allOk); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL max_latency: got %0d expected 3", cyc); end
`ifdef MAC_SAT_EN
    expP = TB_WP'(64'd34359738367);
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL max_ovf: got %b expected 1", ovf); end
`else
    expP = TB_WP'(64'd532575944704);
`endif
    checks++; if (out_p !== expP) begin errors++; $display("[TB] FAIL max_out_p: got %0d expected %0d", $signed(out_p), $signed(expP)); end
    out_ready = 1'b1;
    @(negedge clk);
    applyStartStimulus(5'd1);
    applyStimulus(18'(1), 18'(1), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL small_accept: got %b expected 1", ok); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    expP = TB_WP'(1);
    checks++; if (out_p !== expP) begin errors++; $display("[TB] FAIL small_out_p: got %0d expected 1", $signed(out_p)); end
`ifdef MAC_SAT_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL small_ovf: got %b expected 0", ovf); end
`endif
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    bit allOk;
    int cyc;
    logic [TB_WP-1:0] expP;
    allOk     = 1'b1;
    out_ready = 1'b0;
    applyStartStimulus(5'd4);
    applyStimulus(18'(3), 18'(4), ok);  allOk &= ok;
    applyStimulus(18'(6), 18'(7), ok);  allOk &= ok;
    checks++; if (allOk !== 1'b1) begin errors++; $display("[TB] FAIL mid_accept: got %b expected 1", allOk); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_p !== '0) begin errors++; $display("[TB] FAIL mid_out_p: got %0d expected 0", $signed(out_p)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    @(negedge clk);
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_partial: got %b expected 0", out_valid); end
    out_ready = 1'b1;
    applyStartStimulus(5'd1);
    applyStimulus(18'(5), 18'(5), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_accept: got %b expected 1", ok); end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL mid_new_latency: got %0d expected 3", cyc); end
    expP = TB_WP'(25);
    checks++; if (out_p !== expP) begin errors++; $display("[TB] FAIL mid_new_out_p: got %0d expected 25", $signed(out_p)); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rstn      = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic_burst();
    test_bubbles_backpressure();
    test_zero_len();
    test_max_magnitude();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mac_stream_seq.md
Name: mac_stream_seq

Overview:
- Streaming multiply-accumulate sequencer for the DSP48A1 datapath.
- Consumes a burst of signed A/B operand pairs through a valid/ready handshake, then pushes them through a registered A/B → M → P pipeline.
- Returns one accumulated result through a valid/ready handshake.
- It is the consumer/driver end of the slice's pipeline registers: it generates their clock enables and clears internally, so no external CE/RST wiring is needed.

Parameters:
- WIDTH_A, 18, A operand width (signed)
- WIDTH_B, 18, B operand width (signed)
- WIDTH_P, 48, accumulator/result width (signed); must be ≥ WIDTH_A+WIDTH_B
- LEN_W, 5, width of the burst-length field; max burst = 2^LEN_W-1

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous, active-high reset; 1 = clear all state
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE
- len  input  LEN_W  number of operand pairs in the burst; sampled with start
- in_valid  input  1  operand pair valid
- in_ready  output  1  sequencer accepts an operand pair this cycle
- in_a  input  WIDTH_A  signed A operand
- in_b  input  WIDTH_B  signed B operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_p  output  WIDTH_P  signed accumulated result
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rstn=1):
  - state=IDLE; all pipeline registers, valid bits, counters and the accumulator = 0.
  - in_ready=0, out_valid=0, out_p=0, busy=0.
  - Reset mid-burst aborts the burst; no partial result is ever emitted.
- States:
  - IDLE: start=1 latches len, clears acc and cnt. Goes to RUN if len≠0, else to OUT with out_p=0.
  - RUN: in_ready=(cnt<len_q). A beat is accepted when in_valid&&in_ready; cnt increments on acceptance. Goes to DRAIN the cycle after cnt reaches len_q.
  - DRAIN: in_ready=0. Goes to OUT once v1=0 and v2=0 and the final product has been accumulated.
  - OUT: out_valid=1, out_p=acc held stable until out_valid&&out_ready, then IDLE.
- Pipeline:
  - Stage 1: a_r/b_r load on accept; v1 = accept.
  - Stage 2: m_r = a_r*b_r, full-width signed; v2 = v1.
  - Stage 3: when v2=1, acc += sign_extend(m_r, WIDTH_P).
  - Bubbles (in_valid=0) carry v=0 and leave acc unchanged.
- Latency: last beat accepted at edge t → out_valid=1 after edge t+3. Throughput is one beat per cycle.
- Arithmetic: two's complement throughout. By default the sum wraps modulo 2^WIDTH_P.
- Boundaries:
  - start outside IDLE is ignored, including start asserted in the same cycle as the OUT handshake; it is accepted only on a later IDLE cycle.
  - in_valid while in_ready=0 is ignored (no buffering).
  - len = max value (31 at default) is supported.
  - out_ready held high in OUT gives exactly one result cycle.

Optional Feature:
- Macro: MAC_SAT_EN
- Defined:
  - Stage 3 saturates to +(2^(WIDTH_P-1)-1) / -(2^(WIDTH_P-1)) on signed overflow; once saturated, later products keep accumulating from the clamped value.
  - Adds output port ovf (1 bit), sticky per burst: cleared on burst start and on reset, valid alongside out_valid.
- Undefined: wrap-around arithmetic and no ovf port.

Decomposition:
- Shared package mac_pkg:
  - state enum {IDLE, RUN, DRAIN, OUT}
  - default width constants
  - sign-extend / saturate helper functions
- Sub-module dsp_pipe_reg: parameterized WIDTH register with clock enable and async active-high clear, instantiated for a_r, b_r, m_r and acc.

Test Plan:
- Basic burst: start, len=3, beats (2,3),(−4,5),(7,−1) back-to-back, out_ready=1 → out_valid exactly 3 cycles after the last accept, out_p=−21, then IDLE and busy=0.
- Bubbles and backpressure: len=2, in_valid gapped by 2 idle cycles, out_ready low for 4 cycles → out_p=a0*b0+a1*b1 held stable and out_valid high for all 4 cycles; in_ready=0 after 2 beats.
- Zero length: start with len=0 → out_valid the next cycle with out_p=0; no beats accepted.
- Max magnitude (default): len=31, every beat (−131072,−131072) → out_p=31·2^34=532575944704, no wrap at WIDTH_P=48.
- Reset mid-burst: rstn=1 pulse after 2 of 4 beats → all outputs 0, IDLE; a new len=1 burst (5,5) gives out_p=25.
- MAC_SAT_EN, WIDTH_P=36: len=31 beats (−131072,−131072) → out_p=2^35−1, ovf=1; next burst (1,1) → out_p=1, ovf=0.
